mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Four-requester arbiter in front of one shared sequential signed multiplier.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (0 highest) instead of round-robin.
module mult_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_in,
    input  logic [4*WIDTH-1:0]   b_in,
    output logic [3:0]           gnt,
    output logic [3:0]           rsp_valid,
    output logic [2*WIDTH-1:0]   rsp_p,
    output logic                 busy,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    input  logic                 mul_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           winner_q, winner_d;
    logic                 first_wait_q, first_wait_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [3:0]           rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_p_q, rsp_p_d;
    logic                 busy_q, busy_d;
    logic                 mul_start_q, mul_start_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
    logic [1:0]           last_grant_q, last_grant_d;
`endif

    logic [WIDTH-1:0]     a_arr [4];
    logic [WIDTH-1:0]     b_arr [4];
    logic [1:0]           pick;
    logic                 pick_vld;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Walk candidates from lowest to highest priority so the best match is written last.
    always_comb begin
        pick_vld = |req;
        pick     = 2'd0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) pick = 2'(k);
        end
`else
        for (int k = 3; k >= 0; k--) begin
            logic [1:0] idx;
            idx = last_grant_q + 2'(k + 1);
            if (req[idx]) pick = idx;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        first_wait_d = first_wait_q;
        gnt_d        = 4'b0000;
        rsp_valid_d  = 4'b0000;
        rsp_p_d      = rsp_p_q;
        mul_start_d  = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
`ifndef MULT_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = START;
                    winner_d    = pick;
                    gnt_d       = 4'b0001 << pick;
                    mul_start_d = 1'b1;
                    mul_a_d     = a_arr[pick];
                    mul_b_d     = b_arr[pick];
                end
            end
            START: begin
                state_d      = WAIT;
                first_wait_d = 1'b1;
`ifndef MULT_ARB_FIXED_PRIO_EN
                last_grant_d = winner_q;
`endif
            end
            WAIT: begin
                // done may still be high from the previous multiply on the first WAIT cycle
                if (first_wait_q) begin
                    first_wait_d = 1'b0;
                end else if (mul_done) begin
                    rsp_p_d     = mul_p;
                    rsp_valid_d = 4'b0001 << winner_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            winner_q     <= 2'd0;
            first_wait_q <= 1'b0;
            gnt_q        <= 4'b0000;
            rsp_valid_q  <= 4'b0000;
            rsp_p_q      <= '0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
`ifndef MULT_ARB_FIXED_PRIO_EN
            last_grant_q <= 2'd3;
`endif
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            first_wait_q <= first_wait_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_p_q      <= rsp_p_d;
            busy_q       <= busy_d;
            mul_start_q  <= mul_start_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
`ifndef MULT_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
